switch_input_conditioner: RTL and testbench



---
 rtl/switch_input_conditioner.sv | 137 +++++++++++++
 tb/tb_switch_input_conditioner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input_conditioner.sv
// -----------------------------------------------------------------------------
// switch_input_conditioner
//
// Cleans the raw board slide-switch bus before it reaches the core's
// `switches` input. Each bit is conditioned independently:
//   raw pin -> 2-flop synchroniser -> stability-count debouncer -> change pulse
//
// A synchronised bit must differ from its current output on STABLE_CYCLES
// consecutive edges before the output takes the new value. Any edge where
// the bit agrees with the output again clears that bit's count, so short
// glitches never reach the core.
//
// Optional feature (macro SWITCH_COND_IRQ_EN):
//   defined   - `irq` is a sticky flag set whenever any output bit updates
//               and cleared by `irq_clear`. A set in the same cycle as a
//               clear wins.
//   undefined - `irq` is tied low and `irq_clear` is ignored; no flop exists.
//
// Parameters:
//   WIDTH         number of switch bits conditioned
//   STABLE_CYCLES consecutive differing cycles needed to accept a change (>= 1)
//   RESET_VALUE   value of `switches_out` during and right after reset
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   switches_raw in   unsynchronised switch pins [WIDTH]
//   switches_out out  debounced switch value to the core [WIDTH]
//   changed      out  one-cycle pulse per bit when switches_out bit updates
//   irq          out  sticky change flag (see optional feature)
//   irq_clear    in   clears irq
// -----------------------------------------------------------------------------
module switch_input_conditioner #(
    parameter int unsigned       WIDTH         = 16,
    parameter int unsigned       STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches_raw,
    output logic [WIDTH-1:0] switches_out,
    output logic [WIDTH-1:0] changed,
    output logic             irq,
    input  logic             irq_clear
);

    // Counter only has to reach STABLE_CYCLES-1, so clog2 bits suffice;
    // keep at least one bit so STABLE_CYCLES of 1 or 2 still elaborates.
    localparam int unsigned     CW       = ($clog2(STABLE_CYCLES) > 1) ?
                                           $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]           r_sync1;
    logic [WIDTH-1:0]           r_sync2;
    logic [WIDTH-1:0][CW-1:0]   r_cnt;
    logic [WIDTH-1:0]           r_out;
    logic [WIDTH-1:0]           r_changed;

    logic [WIDTH-1:0][CW-1:0]   w_cnt_next;
    logic [WIDTH-1:0]           w_out_next;
    logic [WIDTH-1:0]           w_changed_next;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= switches_raw;
            r_sync2 <= r_sync1;
        end
    end

    // -------------------------------------------------------------------------
    // Per-bit debounce decision
    // -------------------------------------------------------------------------
    always_comb begin
        w_cnt_next     = r_cnt;
        w_out_next     = r_out;
        w_changed_next = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] == r_out[i]) begin
                // Agreement (or a glitch that came back) discards any count.
                w_cnt_next[i] = '0;
            end else if (r_cnt[i] == CNT_LAST) begin
                w_out_next[i]     = r_sync2[i];
                w_cnt_next[i]     = '0;
                w_changed_next[i] = 1'b1;
            end else begin
                w_cnt_next[i] = r_cnt[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_out     <= RESET_VALUE;
            r_changed <= '0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_out     <= w_out_next;
            r_changed <= w_changed_next;
        end
    end

    assign switches_out = r_out;
    assign changed      = r_changed;

    // -------------------------------------------------------------------------
    // Sticky change interrupt
    // -------------------------------------------------------------------------
`ifdef SWITCH_COND_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (|w_changed_next) begin
            // A new change outranks a simultaneous clear.
            r_irq <= 1'b1;
        end else if (irq_clear) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_clear;

    assign w_unused_irq_clear = irq_clear;
    assign irq                = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_switch_input_conditioner
//
// Drives two conditioners from the same switch bus: one with STABLE_CYCLES=4
// and one with STABLE_CYCLES=1. A reference model built from sample history
// (a bit flips once its last STABLE_CYCLES synchronised samples all disagree
// with the current output) is compared against both DUTs on every falling
// edge, and directed checks with hand-computed values pin the model.
// -----------------------------------------------------------------------------
module tb_switch_input_conditioner;

    localparam int unsigned W = 16;
    localparam int unsigned S [2] = '{4, 1};

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] raw;
    logic         irq_clear;

    logic [W-1:0] out0, chg0, out1, chg1;
    logic         irq0, irq1;

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;

    always #5 clk = ~clk;

    switch_input_conditioner #(
        .WIDTH         (W),
        .STABLE_CYCLES (4),
        .RESET_VALUE   (16'h0000)
    ) dut0 (
        .clk          (clk),
        .reset        (reset),
        .switches_raw (raw),
        .switches_out (out0),
        .changed      (chg0),
        .irq          (irq0),
        .irq_clear    (irq_clear)
    );

    switch_input_conditioner #(
        .WIDTH         (W),
        .STABLE_CYCLES (1),
        .RESET_VALUE   (16'h0000)
    ) dut1 (
        .clk          (clk),
        .reset        (reset),
        .switches_raw (raw),
        .switches_out (out1),
        .changed      (chg1),
        .irq          (irq1),
        .irq_clear    (irq_clear)
    );

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [W-1:0] raw_q [$];   // raw value sampled at each edge since reset
    logic [W-1:0] s2_q  [$];   // synchronised value seen at each edge
    logic [W-1:0] m_out [2];
    logic [W-1:0] m_chg [2];
    logic         m_irq [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            raw_q.delete();
            s2_q.delete();
            for (int d = 0; d < 2; d++) begin
                m_out[d] = 16'h0000;
                m_chg[d] = 16'h0000;
                m_irq[d] = 1'b0;
            end
        end else begin
            logic [W-1:0] s2;
            // Value after two sampling edges; zero until the pipeline fills.
            s2 = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 16'h0000;
            s2_q.push_back(s2);
            raw_q.push_back(raw);
            for (int d = 0; d < 2; d++) begin
                logic [W-1:0] nxt;
                nxt = m_out[d];
                m_chg[d] = 16'h0000;
                for (int b = 0; b < W; b++) begin
                    bit all_diff;
                    all_diff = (s2_q.size() >= S[d]);
                    for (int k = 1; k <= S[d] && all_diff; k++)
                        if (s2_q[s2_q.size()-k][b] == m_out[d][b]) all_diff = 0;
                    if (all_diff) begin
                        nxt[b]      = ~m_out[d][b];
                        m_chg[d][b] = 1'b1;
                    end
                end
                m_out[d] = nxt;
`ifdef SWITCH_COND_IRQ_EN
                if (|m_chg[d])      m_irq[d] = 1'b1;
                else if (irq_clear) m_irq[d] = 1'b0;
`else
                m_irq[d] = 1'b0;
`endif
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model out0", out0, m_out[0]);
        chk("model chg0", chg0, m_chg[0]);
        chk("model irq0", {15'h0, irq0}, {15'h0, m_irq[0]});
        chk("model out1", out1, m_out[1]);
        chk("model chg1", chg1, m_chg[1]);
        chk("model irq1", {15'h0, irq1}, {15'h0, m_irq[1]});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    initial begin
        reset     = 1'b1;
        raw       = 16'h8CEF;
        irq_clear = 1'b0;
        #8 reset  = 1'b0;

        // Reset release with stable raw input
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("rel out0 hold", out0, 16'h0000);
            if (e == 3) chk("rel out1 edge3", out1, 16'h8CEF);
        end
        tick();
        chk("rel out0 edge6", out0, 16'h8CEF);
        chk("rel chg0 edge6", chg0, 16'h8CEF);
        tick();
        chk("rel chg0 edge7", chg0, 16'h0000);
`ifdef SWITCH_COND_IRQ_EN
        chk("rel irq0 set", {15'h0, irq0}, 16'h0001);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("rel irq0 clr", {15'h0, irq0}, 16'h0000);
`else
        chk("rel irq0 off", {15'h0, irq0}, 16'h0000);
`endif
        repeat (2) tick();

        // Glitch on bit0 for three sampled edges
        raw = 16'h8CEE;
        repeat (3) tick();
        raw = 16'h8CEF;
        for (int e = 0; e < 8; e++) begin
            chk("glitch out0", out0, 16'h8CEF);
            chk("glitch chg0", chg0, 16'h0000);
            tick();
        end

        // Valid change on bit15
        raw = 16'h0CEF;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("bit15 out0 hold", out0, 16'h8CEF);
        end
        tick();
        chk("bit15 out0 edge6", out0, 16'h0CEF);
        chk("bit15 chg0 edge6", chg0, 16'h8000);
        tick();
        chk("bit15 chg0 after", chg0, 16'h0000);
`ifdef SWITCH_COND_IRQ_EN
        repeat (3) tick();
        chk("irq0 sticky", {15'h0, irq0}, 16'h0001);
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("irq0 cleared", {15'h0, irq0}, 16'h0000);
        // Clear coincides with the next update edge: set wins
        raw = 16'h8CEF;
        repeat (5) tick();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        chk("irq0 set wins out", out0, 16'h8CEF);
        chk("irq0 set wins", {15'h0, irq0}, 16'h0001);
`else
        chk("irq0 tied low", {15'h0, irq0}, 16'h0000);
        chk("irq1 tied low", {15'h0, irq1}, 16'h0000);
`endif
        repeat (3) tick();

        // Reset in the middle of a count
        raw = 16'hFFFF;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("midrst out0", out0, 16'h0000);
        chk("midrst chg0", chg0, 16'h0000);
        chk("midrst irq0", {15'h0, irq0}, 16'h0000);
        #1 reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("midrst out0 hold", out0, 16'h0000);
        end
        tick();
        chk("midrst out0 edge6", out0, 16'hFFFF);
        chk("midrst chg0 edge6", chg0, 16'hFFFF);

        // Single-cycle stability build
        raw = 16'h0000;
        repeat (8) tick();
        chk("s1 out1 base", out1, 16'h0000);
        raw = 16'h0001;
        tick();
        chk("s1 out1 edge1", out1, 16'h0000);
        tick();
        chk("s1 out1 edge2", out1, 16'h0000);
        tick();
        chk("s1 out1 edge3", out1, 16'h0001);
        chk("s1 chg1 edge3", chg1, 16'h0001);
        tick();
        chk("s1 chg1 edge4", chg1, 16'h0000);
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
